axi_bus_arbiter: RTL



---
 rtl/axi_bus_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/axi_bus_arbiter.sv
`timescale 1ns/1ps
// axi_bus_arbiter
// Shares one simple a/b-channel slave bus between two masters (m0, m1).
// One transaction is granted at a time in round-robin order; the response is
// routed back to the owning master, and a timeout error response is produced
// if the slave does not answer within TIMEOUT cycles of the address handshake.
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   mN_avalid/aready          : master N request handshake
//   mN_awe/aaddr/adata/astrb  : master N request fields (word address [31:2])
//   mN_bvalid/bdata/berr      : master N response pulse, read data, timeout flag
//   s_avalid/aready           : slave request handshake
//   s_awe/aaddr/adata/astrb   : slave request fields (muxed from the owner)
//   s_bvalid/bdata            : slave response pulse and read data
module axi_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_avalid,
    output logic        m0_aready,
    input  logic        m0_awe,
    input  logic [31:2] m0_aaddr,
    input  logic [31:0] m0_adata,
    input  logic [3:0]  m0_astrb,
    output logic        m0_bvalid,
    output logic [31:0] m0_bdata,
    output logic        m0_berr,
    input  logic        m1_avalid,
    output logic        m1_aready,
    input  logic        m1_awe,
    input  logic [31:2] m1_aaddr,
    input  logic [31:0] m1_adata,
    input  logic [3:0]  m1_astrb,
    output logic        m1_bvalid,
    output logic [31:0] m1_bdata,
    output logic        m1_berr,
    output logic        s_avalid,
    input  logic        s_aready,
    output logic        s_awe,
    output logic [31:2] s_aaddr,
    output logic [31:0] s_adata,
    output logic [3:0]  s_astrb,
    input  logic        s_bvalid,
    input  logic [31:0] s_bdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // TIMEOUT == 0 disables the timeout; TCNT_LAST is then never used.
    localparam bit          TO_EN     = (TIMEOUT != 32'd0);
    localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 32'd1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner;
    logic        w_owner_nxt;
    logic        r_last;
    logic        w_last_nxt;
    logic [15:0] r_tcnt;
    logic [15:0] w_tcnt_nxt;

    logic        w_own_avalid;
    logic        w_timeout;
    logic        w_resp;
    logic [31:0] w_rsp_data;
    logic        w_rsp_err;

    assign w_own_avalid = r_owner ? m1_avalid : m0_avalid;
    assign w_timeout    = TO_EN && (r_tcnt == TCNT_LAST);
    // A real slave response always wins over a coincident timeout.
    assign w_resp       = s_bvalid || w_timeout;
    assign w_rsp_data   = s_bvalid ? s_bdata : ERR_DATA;
    assign w_rsp_err    = ~s_bvalid;

    // State register: FSM state, owner, round-robin history and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_tcnt  <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    // Next-state logic: arbitration in IDLE, handshake in ADDR, response/timeout in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_tcnt_nxt  = r_tcnt;
        case (r_state)
            ST_IDLE: begin
                if (m0_avalid && m1_avalid) begin
                    // Tie: the master not served last time wins.
                    w_owner_nxt = ~r_last;
                    w_state_nxt = ST_ADDR;
                end else if (m0_avalid || m1_avalid) begin
                    w_owner_nxt = m1_avalid;
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (!w_own_avalid) begin
                    // Owner withdrew its request: abandon without touching r_last.
                    w_state_nxt = ST_IDLE;
                end else if (s_aready) begin
                    w_state_nxt = ST_WAIT;
                    w_tcnt_nxt  = 16'd0;
                    w_last_nxt  = r_owner;
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_WAIT: begin
                if (w_resp) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: request mux toward the slave and response routing to the owner.
    always_comb begin
        m0_aready = 1'b0;
        m1_aready = 1'b0;
        m0_bvalid = 1'b0;
        m1_bvalid = 1'b0;
        m0_bdata  = 32'd0;
        m1_bdata  = 32'd0;
        m0_berr   = 1'b0;
        m1_berr   = 1'b0;
        s_avalid  = 1'b0;
        s_awe     = 1'b0;
        s_aaddr   = 30'd0;
        s_adata   = 32'd0;
        s_astrb   = 4'd0;
        case (r_state)
            ST_ADDR: begin
                s_avalid = w_own_avalid;
                if (r_owner) begin
                    s_awe     = m1_awe;
                    s_aaddr   = m1_aaddr;
                    s_adata   = m1_adata;
                    s_astrb   = m1_astrb;
                    m1_aready = s_aready;
                end else begin
                    s_awe     = m0_awe;
                    s_aaddr   = m0_aaddr;
                    s_adata   = m0_adata;
                    s_astrb   = m0_astrb;
                    m0_aready = s_aready;
                end
            end
            ST_WAIT: begin
                if (w_resp && r_owner) begin
                    m1_bvalid = 1'b1;
                    m1_bdata  = w_rsp_data;
                    m1_berr   = w_rsp_err;
                end else if (w_resp) begin
                    m0_bvalid = 1'b1;
                    m0_bdata  = w_rsp_data;
                    m0_berr   = w_rsp_err;
                end else begin
                    s_avalid = 1'b0;
                end
            end
            default: begin
                s_avalid = 1'b0;
            end
        endcase
    end

endmodule
